// File: rtl/ysyx_24100006_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100006_pkg
//  Description : Shared constants for the NPC core. This file holds the IFU
//                fetch-sequencer state encoding, the fault codes handed to the
//                IDU, and the AXI4-Lite read response codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24100006_pkg;

    // IFU fetch sequencer state encoding
    localparam logic [1:0] ADDR   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] OUT    = 2'd2;
    localparam logic [1:0] WAITPC = 2'd3;

    typedef enum logic [1:0] {
        S_ADDR   = ADDR,
        S_DATA   = DATA,
        S_OUT    = OUT,
        S_WAITPC = WAITPC
    } ifu_state_t;

    // Instruction fault codes presented to the IDU (2'b11 is reserved)
    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_ACCESS   = 2'b01;
    localparam logic [1:0] FAULT_MISALIGN = 2'b10;

    // AXI read response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage : ysyx_24100006_pkg
`default_nettype wire

// File: rtl/ysyx_24100006_Reg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100006_Reg
//  Description : Generic enabled register with a synchronous active-high reset.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset (loads RESET_VAL)
//                wen  - write enable
//                din  - next value
//                dout - registered value
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100006_Reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule : ysyx_24100006_Reg
`default_nettype wire

// File: rtl/ysyx_24100006_ifu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100006_ifu_ctrl
//  Description : IF-stage fetch sequencer. It owns the PC and issues one
//                AXI4-Lite read per instruction. It hands the fetched word, or
//                a fault code, to the IDU. It then waits for the next PC before
//                starting the next fetch. Only one instruction is in flight.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                pc                    - current fetch PC
//                araddr/arvalid/arready- AXI read address channel
//                rdata/rresp/rvalid/rready - AXI read data channel
//                inst/inst_fault/inst_valid/inst_ready - IDU handoff
//                npc/npc_valid/npc_ready - next PC from WB/branch/trap logic
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100006_ifu_ctrl
    import ysyx_24100006_pkg::*;
#(
`ifdef YSYXSOC
    parameter logic [31:0] RESET_PC = 32'h3000_0000
`else
    parameter logic [31:0] RESET_PC = 32'h8000_0000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [1:0]  inst_fault,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    output logic        npc_ready
);

    ifu_state_t  r_state;
    ifu_state_t  w_next_state;
    logic        r_rst_hold;
    logic [31:0] r_inst;
    logic [1:0]  r_fault;
    logic        w_pc_wen;
    logic        w_misaligned;
    logic        w_access_err;
    logic        w_addr_active;

    // PC register: written only in the cycle the npc handshake completes
    assign w_pc_wen = npc_valid & npc_ready;

    ysyx_24100006_Reg #(
        .WIDTH     (32),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (reset),
        .wen  (w_pc_wen),
        .din  (npc),
        .dout (pc)
    );

    assign araddr       = pc;
    assign w_misaligned = (pc[1:0] != 2'b00);
    assign w_access_err = (rresp == RESP_SLVERR) || (rresp == RESP_DECERR);

    // r_rst_hold keeps ADDR idle for the first cycle after reset drops. The
    // first arvalid therefore appears the cycle after reset falls. No
    // combinational path runs from reset to the bus.
    assign w_addr_active = (r_state == S_ADDR) && !r_rst_hold;

    assign inst       = r_inst;
    assign inst_fault = r_fault;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_ADDR;
            r_rst_hold <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_rst_hold <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        arvalid      = 1'b0;
        rready       = 1'b0;
        inst_valid   = 1'b0;
        npc_ready    = 1'b0;
        case (r_state)
            S_ADDR: begin
                if (w_addr_active) begin
                    if (w_misaligned) begin
                        // A misaligned PC is reported directly and never
                        // reaches the bus.
                        w_next_state = S_OUT;
                    end else begin
                        arvalid = 1'b1;
                        if (arready) begin
                            w_next_state = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_next_state = S_OUT;
                end
            end
            S_OUT: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    w_next_state = S_WAITPC;
                end
            end
            S_WAITPC: begin
                npc_ready = 1'b1;
                if (npc_valid) begin
                    w_next_state = S_ADDR;
                end
            end
            default: begin
                w_next_state = S_ADDR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction / fault latch. The contents stay fixed while in OUT, so
    // the IDU payload is stable until it is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst  <= 32'h0;
            r_fault <= FAULT_NONE;
        end else if (w_addr_active && w_misaligned) begin
            r_inst  <= 32'h0;
            r_fault <= FAULT_MISALIGN;
        end else if (rready && rvalid) begin
            r_inst  <= w_access_err ? 32'h0 : rdata;
            r_fault <= w_access_err ? FAULT_ACCESS : FAULT_NONE;
        end
    end

endmodule : ysyx_24100006_ifu_ctrl
`default_nettype wire

// File: tb/tb_ysyx_24100006_ifu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24100006_ifu_ctrl
//  Description : Self-checking bench for the IFU fetch sequencer. A vector
//                table drives one fetch per record. Expected IDU payloads are
//                queued when a fetch starts and compared on acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100006_ifu_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [1:0]  inst_fault;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] npc;
    logic        npc_valid;
    logic        npc_ready;

    int n_applied;
    int n_miscompares;

    typedef struct {
        logic [31:0] addr;       // PC expected on araddr
        int          ar_stall;   // cycles arready held low
        int          r_stall;    // cycles rvalid delayed
        int          ir_stall;   // cycles inst_ready held low
        int          npc_stall;  // cycles npc_valid delayed
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] next_pc;
        logic [31:0] exp_inst;
        logic [1:0]  exp_fault;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  fault;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[9];

    ysyx_24100006_ifu_ctrl #(
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_fault (inst_fault),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .npc        (npc),
        .npc_valid  (npc_valid),
        .npc_ready  (npc_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; the bench samples and drives 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One complete fetch loop. Each phase runs for an exact cycle count,
    // so every stall adds precisely its own length to the loop.
    task automatic run_vector(input vec_t v);
        exp_t e;
        e.pc    = v.addr;
        e.inst  = v.exp_inst;
        e.fault = v.exp_fault;
        exp_q.push_back(e);

        if (v.addr[1:0] == 2'b00) begin
            for (int i = 0; i <= v.ar_stall; i++) begin
                arready = (i == v.ar_stall);
                chk1("arvalid", arvalid, 1'b1);
                chk32("araddr", araddr, v.addr);
                chk1("rready_in_addr", rready, 1'b0);
                tick();
            end
            arready = 1'b0;
            for (int i = 0; i <= v.r_stall; i++) begin
                rvalid = (i == v.r_stall);
                rdata  = (i == v.r_stall) ? v.data : $urandom;
                rresp  = v.resp;
                chk1("rready", rready, 1'b1);
                chk1("arvalid_in_data", arvalid, 1'b0);
                tick();
            end
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'b00;
        end else begin
            // Offer arready; a misaligned PC must never issue a read.
            arready = 1'b1;
            chk1("arvalid_misaligned", arvalid, 1'b0);
            chk1("inst_valid_misaligned", inst_valid, 1'b0);
            tick();
            arready = 1'b0;
        end

        for (int i = 0; i <= v.ir_stall; i++) begin
            inst_ready = (i == v.ir_stall);
            // A stray npc offered outside WAITPC must be ignored.
            npc_valid  = (i < v.ir_stall);
            npc        = 32'h1234_5678;
            chk1("inst_valid", inst_valid, 1'b1);
            chk1("npc_ready_in_out", npc_ready, 1'b0);
            if (exp_q.size() == 0) begin
                n_applied++;
                n_miscompares++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                chk32("inst", inst, exp_q[0].inst);
                chk32("inst_fault", {30'h0, inst_fault}, {30'h0, exp_q[0].fault});
                chk32("pc_in_out", pc, exp_q[0].pc);
                if (i == v.ir_stall) begin
                    void'(exp_q.pop_front());
                end
            end
            tick();
        end
        inst_ready = 1'b0;

        for (int i = 0; i <= v.npc_stall; i++) begin
            npc_valid = (i == v.npc_stall);
            npc       = (i == v.npc_stall) ? v.next_pc : $urandom;
            chk1("npc_ready", npc_ready, 1'b1);
            chk1("inst_valid_in_waitpc", inst_valid, 1'b0);
            chk32("pc_in_waitpc", pc, v.addr);
            tick();
        end
        npc_valid = 1'b0;
        chk32("pc_after_npc", pc, v.next_pc);
    endtask

    initial begin
        n_applied     = 0;
        n_miscompares = 0;
        reset      = 1'b1;
        arready    = 1'b0;
        rdata      = 32'h0;
        rresp      = 2'b00;
        rvalid     = 1'b0;
        inst_ready = 1'b0;
        npc        = 32'h0;
        npc_valid  = 1'b0;

        //            addr          ar r  ir npc resp   data           next_pc        exp_inst       exp_fault
        vecs[0] = '{32'h8000_0000, 0, 0, 0, 0, 2'b00, 32'h0000_0013, 32'h8000_0004, 32'h0000_0013, 2'b00};
        vecs[1] = '{32'h8000_0004, 0, 0, 0, 0, 2'b00, 32'h0000_0013, 32'h8000_0008, 32'h0000_0013, 2'b00};
        vecs[2] = '{32'h8000_0008, 5, 3, 2, 0, 2'b00, 32'h0050_0093, 32'h8000_000C, 32'h0050_0093, 2'b00};
        vecs[3] = '{32'h8000_000C, 0, 0, 0, 0, 2'b10, 32'hDEAD_BEEF, 32'h8000_0100, 32'h0000_0000, 2'b01};
        vecs[4] = '{32'h8000_0100, 1, 0, 0, 2, 2'b11, 32'h0000_1234, 32'h8000_0104, 32'h0000_0000, 2'b01};
        vecs[5] = '{32'h8000_0104, 0, 1, 0, 0, 2'b00, 32'h0000_ABCD, 32'h8000_0002, 32'h0000_ABCD, 2'b00};
        vecs[6] = '{32'h8000_0002, 0, 0, 1, 0, 2'b00, 32'h0000_0000, 32'h8000_0011, 32'h0000_0000, 2'b10};
        vecs[7] = '{32'h8000_0011, 0, 0, 0, 1, 2'b00, 32'h0000_0000, 32'h8000_0010, 32'h0000_0000, 2'b10};
        vecs[8] = '{32'h8000_0010, 0, 0, 0, 0, 2'b01, 32'h5555_AAAA, 32'h8000_0014, 32'h5555_AAAA, 2'b00};

        // Reset held for 3 cycles: outputs stay at reset values.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("arvalid_reset", arvalid, 1'b0);
            chk1("rready_reset", rready, 1'b0);
            chk1("inst_valid_reset", inst_valid, 1'b0);
            chk1("npc_ready_reset", npc_ready, 1'b0);
            chk32("pc_reset", pc, 32'h8000_0000);
            chk32("inst_reset", inst, 32'h0);
            chk32("fault_reset", {30'h0, inst_fault}, 32'h0);
        end
        reset = 1'b0;
        chk1("arvalid_reset_fall", arvalid, 1'b0);
        tick();
        chk1("arvalid_first", arvalid, 1'b1);
        chk32("araddr_first", araddr, 32'h8000_0000);

        for (int k = 0; k < 9; k++) begin
            run_vector(vecs[k]);
        end

        // Reset in the middle of DATA; a stray rvalid afterwards is ignored.
        arready = 1'b1;
        chk1("arvalid_pre_rst", arvalid, 1'b1);
        tick();
        arready = 1'b0;
        chk1("rready_pre_rst", rready, 1'b1);
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hCAFE_F00D;
        chk1("rready_post_rst", rready, 1'b0);
        chk1("arvalid_post_rst", arvalid, 1'b0);
        chk32("pc_post_rst", pc, 32'h8000_0000);
        tick();
        chk1("rready_stray", rready, 1'b0);
        chk1("arvalid_after_rst", arvalid, 1'b1);
        chk32("inst_after_stray", inst, 32'h0);
        rvalid = 1'b0;
        run_vector('{32'h8000_0000, 0, 0, 0, 0, 2'b00, 32'h0000_0077,
                     32'h8000_0004, 32'h0000_0077, 2'b00});

        n_applied++;
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule : tb_ysyx_24100006_ifu_ctrl
`default_nettype wire
